if_instr_buffer: RTL and testbench
==================================

IF_INSTR_BUFFER -- requirements
Module: if_instr_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of buffered fetch entries; power of two, at least 2.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port Fetch_Valid  input  1  fetch unit presents an entry this cycle.
REQ-005 SHALL have port Fetch_Instr  input  32  fetched instruction word.
REQ-006 SHALL have port Fetch_PC  input  32  PC of the fetched instruction.
REQ-007 SHALL have port Fetch_ExceptType  input  ExceptinPipeType  fetch-side exception flags; opaque, carried unchanged.
REQ-008 SHALL have port Fetch_Ready  output  1  buffer can accept an entry this cycle.
REQ-009 SHALL have port IF_Flush  input  1  discard all buffered entries.
REQ-010 SHALL have port ID_Wr  input  1  decode register captures the head entry this cycle.
REQ-011 SHALL have port IF_Instr  output  32  head instruction to the decode register.
REQ-012 SHALL have port IF_PC  output  32  head PC to the decode register.
REQ-013 SHALL have port IF_ExceptType  output  ExceptinPipeType  head exception flags to the decode register.
REQ-014 SHALL have port IF_Valid  output  1  head entry is valid.
REQ-015 SHALL have port Buf_Count  output  $clog2(DEPTH)+1  number of occupied entries.

Function
REQ-016 SHALL be a circular FIFO: write pointer, read pointer and count, each $clog2(DEPTH) bits plus count MSB; pointers wrap from DEPTH-1 to 0.
REQ-017 SHALL drive Fetch_Ready = (Buf_Count < DEPTH) and not IF_Flush, combinationally.
REQ-018 SHALL push {Fetch_Instr, Fetch_PC, Fetch_ExceptType} when Fetch_Valid and Fetch_Ready are both high.
REQ-019 SHALL drive IF_Valid = (Buf_Count != 0).
REQ-020 SHALL pop the head when ID_Wr and IF_Valid are both high; ID_Wr with IF_Valid low SHALL change no state.
REQ-021 SHALL drive IF_Instr, IF_PC and IF_ExceptType from the head entry when IF_Valid is high, and all-zero (bubble, instruction 32'h0 = nop) when IF_Valid is low.
REQ-022 SHALL have no bypass: an entry pushed at edge N appears on the IF_* outputs after edge N, not before.
REQ-023 SHALL, on a simultaneous push and pop, advance both pointers and leave Buf_Count unchanged, including when Buf_Count is DEPTH-1.
REQ-024 SHALL, when Buf_Count equals DEPTH, refuse a push (Fetch_Ready low) even when a pop occurs in the same cycle.
REQ-025 SHALL, when empty, not pop a push arriving in the same cycle; that entry becomes the head after the edge.
REQ-026 SHALL, on IF_Flush high at an edge, zero both pointers and the count, and drop any same-cycle push and pop.
REQ-027 SHALL preserve entry order exactly; Fetch_ExceptType SHALL stay attached to its own instruction and PC.
REQ-028 SHALL leave storage contents unreset; only pointers and count are reset or flushed.

Reset
REQ-029 SHALL, while rst is high, asynchronously force pointers and count to 0, so that IF_Valid=0, IF_* outputs are all-zero, Buf_Count=0 and Fetch_Ready=1.
REQ-030 SHALL, on rst asserted mid-operation, discard all entries immediately without waiting for a clock edge.
REQ-031 SHALL accept a push at the first rising edge after rst deasserts.

Verification
REQ-032 Bench SHALL cover basic flow: push PC 0x1000 and 0x1004 with ID_Wr=0 -> Buf_Count=2, IF_PC=0x1000; assert ID_Wr for one cycle -> IF_PC=0x1004, Buf_Count=1.
REQ-033 Bench SHALL cover full: push 4 entries with ID_Wr=0 -> Fetch_Ready=0, Buf_Count=4; a 5th Fetch_Valid plus ID_Wr in the same cycle -> 5th entry not stored, Buf_Count=3.
REQ-034 Bench SHALL cover wrap-around: run 10 push/pop pairs -> outputs in order, PCs 0x0 to 0x24 step 4, with no loss.
REQ-035 Bench SHALL cover flush: with 3 entries held, IF_Flush plus Fetch_Valid -> next cycle Buf_Count=0, IF_Instr=0, IF_Valid=0.
REQ-036 Bench SHALL cover empty-with-push: ID_Wr=1 and push of instruction 0x24020001 when empty -> after the edge IF_Instr=0x24020001, Buf_Count=1.
REQ-037 Bench SHALL cover async reset: assert rst between edges with 2 entries held -> IF_Valid=0 and Buf_Count=0 before the next edge.

Source files
------------

// File: rtl/if_instr_buffer.sv
// Fetch-to-decode instruction buffer: a circular FIFO of {instr, pc, except} entries.
// The head is presented to the decode register, or a zero bubble when the buffer is empty.
module if_instr_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter type ExceptinPipeType = logic [7:0]
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       Fetch_Valid,
    input  logic [31:0]                Fetch_Instr,
    input  logic [31:0]                Fetch_PC,
    input  ExceptinPipeType            Fetch_ExceptType,
    output logic                       Fetch_Ready,
    input  logic                       IF_Flush,
    input  logic                       ID_Wr,
    output logic [31:0]                IF_Instr,
    output logic [31:0]                IF_PC,
    output ExceptinPipeType            IF_ExceptType,
    output logic                       IF_Valid,
    output logic [$clog2(DEPTH):0]     Buf_Count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    // Storage is deliberately left unreset; only pointers and count carry state meaning.
    logic [31:0]     instr_mem [DEPTH];
    logic [31:0]     pc_mem    [DEPTH];
    ExceptinPipeType exc_mem   [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;

    logic push;
    logic pop;

    assign Fetch_Ready = (count_q < CNT_FULL) && !IF_Flush;
    assign IF_Valid    = (count_q != '0);
    assign Buf_Count   = count_q;

    assign push = Fetch_Valid && Fetch_Ready;
    assign pop  = ID_Wr && IF_Valid;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (IF_Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= Fetch_Instr;
            pc_mem[wr_ptr_q]    <= Fetch_PC;
            exc_mem[wr_ptr_q]   <= Fetch_ExceptType;
        end
    end

    // Empty buffer presents an all-zero bubble (instruction 0 is a nop).
    always_comb begin
        IF_Instr      = '0;
        IF_PC         = '0;
        IF_ExceptType = '0;
        if (IF_Valid) begin
            IF_Instr      = instr_mem[rd_ptr_q];
            IF_PC         = pc_mem[rd_ptr_q];
            IF_ExceptType = exc_mem[rd_ptr_q];
        end
    end

endmodule

// File: tb/tb_if_instr_buffer.sv
// Self-checking bench for if_instr_buffer: a queue-based model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_if_instr_buffer;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        Fetch_Valid = 1'b0;
    logic [31:0] Fetch_Instr = '0;
    logic [31:0] Fetch_PC = '0;
    logic [7:0]  Fetch_ExceptType = '0;
    logic        Fetch_Ready;
    logic        IF_Flush = 1'b0;
    logic        ID_Wr = 1'b0;
    logic [31:0] IF_Instr;
    logic [31:0] IF_PC;
    logic [7:0]  IF_ExceptType;
    logic        IF_Valid;
    logic [2:0]  Buf_Count;

    int checks = 0;
    int errors = 0;

    if_instr_buffer #(.DEPTH(DEPTH)) dut (
        .clk              (clk),
        .rst              (rst),
        .Fetch_Valid      (Fetch_Valid),
        .Fetch_Instr      (Fetch_Instr),
        .Fetch_PC         (Fetch_PC),
        .Fetch_ExceptType (Fetch_ExceptType),
        .Fetch_Ready      (Fetch_Ready),
        .IF_Flush         (IF_Flush),
        .ID_Wr            (ID_Wr),
        .IF_Instr         (IF_Instr),
        .IF_PC            (IF_PC),
        .IF_ExceptType    (IF_ExceptType),
        .IF_Valid         (IF_Valid),
        .Buf_Count        (Buf_Count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [7:0]  exc;
    } ent_t;

    ent_t mq[$];

    // Model: a plain queue; push is judged on the occupancy before any same-cycle pop.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mq.delete();
        end else if (IF_Flush) begin
            mq.delete();
        end else begin
            automatic bit do_push = Fetch_Valid && (mq.size() < DEPTH);
            automatic bit do_pop  = ID_Wr && (mq.size() > 0);
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back({Fetch_Instr, Fetch_PC, Fetch_ExceptType});
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        automatic bit   v = (mq.size() != 0);
        automatic ent_t h = v ? mq[0] : '0;
        check("cmp_valid", 32'(IF_Valid), 32'(v));
        check("cmp_count", 32'(Buf_Count), 32'(mq.size()));
        check("cmp_ready", 32'(Fetch_Ready), 32'((mq.size() < DEPTH) && !IF_Flush));
        check("cmp_instr", IF_Instr, h.instr);
        check("cmp_pc", IF_PC, h.pc);
        check("cmp_exc", 32'(IF_ExceptType), 32'(h.exc));
    end

    // Applies one cycle of stimulus, then returns inputs to idle 1 time unit after the edge.
    task automatic cyc(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic wr, input logic fl);
        Fetch_Valid      = v;
        Fetch_Instr      = instr;
        Fetch_PC         = pc;
        Fetch_ExceptType = pc[9:2] ^ 8'h5a;
        ID_Wr            = wr;
        IF_Flush         = fl;
        @(posedge clk);
        #1;
        Fetch_Valid = 1'b0;
        ID_Wr       = 1'b0;
        IF_Flush    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_count", 32'(Buf_Count), 32'd0);
        check("rst_valid", 32'(IF_Valid), 32'd0);
        check("rst_ready", 32'(Fetch_Ready), 32'd1);
        check("rst_instr", IF_Instr, 32'd0);
        rst = 1'b0;

        // Basic flow; first push lands on the first edge after reset release.
        cyc(1'b1, 32'h1111_0000, 32'h1000, 1'b0, 1'b0);
        check("basic_first_count", 32'(Buf_Count), 32'd1);
        cyc(1'b1, 32'h1111_0004, 32'h1004, 1'b0, 1'b0);
        check("basic_count2", 32'(Buf_Count), 32'd2);
        check("basic_pc0", IF_PC, 32'h1000);
        check("basic_exc0", 32'(IF_ExceptType), 32'(8'h00 ^ 8'h5a));
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("basic_pc1", IF_PC, 32'h1004);
        check("basic_count1", 32'(Buf_Count), 32'd1);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("basic_drain", 32'(Buf_Count), 32'd0);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        check("pop_empty_noop", 32'(Buf_Count), 32'd0);

        // Full: fifth push refused even with a same-cycle pop.
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'hA000_0000 + i, 32'h2000 + 4 * i, 1'b0, 1'b0);
        check("full_ready", 32'(Fetch_Ready), 32'd0);
        check("full_count", 32'(Buf_Count), 32'd4);
        cyc(1'b1, 32'hDEAD_BEEF, 32'hDEAD, 1'b1, 1'b0);
        check("full_push_pop_count", 32'(Buf_Count), 32'd3);
        for (int i = 1; i < 4; i++) begin
            check("full_order", IF_PC, 32'h2000 + 4 * i);
            cyc(1'b0, '0, '0, 1'b1, 1'b0);
        end
        check("full_drained", 32'(IF_Valid), 32'd0);

        // Wrap-around: ten entries streamed through with simultaneous push/pop.
        cyc(1'b1, 32'hB000_0000, 32'h0, 1'b0, 1'b0);
        for (int i = 1; i < 10; i++) begin
            check("wrap_order", IF_PC, 32'(4 * (i - 1)));
            cyc(1'b1, 32'hB000_0000 + i, 32'(4 * i), 1'b1, 1'b0);
            check("wrap_count", 32'(Buf_Count), 32'd1);
        end
        check("wrap_last_pc", IF_PC, 32'h24);
        check("wrap_last_instr", IF_Instr, 32'hB000_0009);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);

        // Simultaneous push/pop at DEPTH-1 keeps the count.
        for (int i = 0; i < 3; i++) cyc(1'b1, 32'hC000_0000 + i, 32'h3000 + 4 * i, 1'b0, 1'b0);
        cyc(1'b1, 32'hC000_0003, 32'h300C, 1'b1, 1'b0);
        check("dm1_count", 32'(Buf_Count), 32'd3);
        check("dm1_head", IF_PC, 32'h3004);

        // Flush with a same-cycle push and pop.
        cyc(1'b1, 32'hE000_0000, 32'h4000, 1'b1, 1'b1);
        check("flush_count", 32'(Buf_Count), 32'd0);
        check("flush_instr", IF_Instr, 32'd0);
        check("flush_valid", 32'(IF_Valid), 32'd0);

        // Empty with push and ID_Wr: entry is kept and becomes head.
        cyc(1'b1, 32'h2402_0001, 32'h5000, 1'b1, 1'b0);
        check("empty_push_instr", IF_Instr, 32'h2402_0001);
        check("empty_push_count", 32'(Buf_Count), 32'd1);

        // Async reset between edges with two entries held.
        cyc(1'b1, 32'h2402_0002, 32'h5004, 1'b0, 1'b0);
        check("pre_rst_count", 32'(Buf_Count), 32'd2);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_valid", 32'(IF_Valid), 32'd0);
        check("async_rst_count", 32'(Buf_Count), 32'd0);
        check("async_rst_instr", IF_Instr, 32'd0);
        check("async_rst_ready", 32'(Fetch_Ready), 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc(1'b1, 32'h2402_0003, 32'h6000, 1'b0, 1'b0);
        check("post_rst_push", IF_PC, 32'h6000);
        cyc(1'b0, '0, '0, 1'b1, 1'b0);
        @(posedge clk);
        #1;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
